// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one synchronous single-port video RAM between a CPU
// port and a CRTC fetch port. Each access takes four cycles
// (IDLE -> ISSUE -> CAPTURE -> DONE). Video fetches normally win. A streak
// counter lets the CPU in after STARVE_LIMIT back-to-back video grants that
// were made while the CPU was waiting.
//
// Handshake: each REQ is a level held by its requester until the matching
// one-cycle ACK pulse. Address, data and WE are sampled only on the grant
// edge. DO is valid while ACK is high and holds until that port's next read.
// A REQ still high in the IDLE cycle after ACK falls is a new request.
module vram_arbiter #(
    parameter int ADDR_WIDTH   = 13,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  CLK,
    input  logic                  RESET,
    // CPU port
    input  logic                  CPU_REQ,
    input  logic                  CPU_WE,
    input  logic [ADDR_WIDTH-1:0] CPU_A,
    input  logic [7:0]            CPU_DI,
    output logic [7:0]            CPU_DO,
    output logic                  CPU_ACK,
    // CRTC fetch port (read only)
    input  logic                  VID_REQ,
    input  logic [ADDR_WIDTH-1:0] VID_A,
    output logic [7:0]            VID_DO,
    output logic                  VID_ACK,
    // RAM port (registered outputs)
    output logic [ADDR_WIDTH-1:0] RAM_ADDR,
    output logic [7:0]            RAM_WD,
    output logic                  RAM_WE,
    input  logic [7:0]            RAM_Q,
    // Debug view of the FSM state (IDLE=0, ISSUE=1, CAPTURE=2, DONE=3)
    output logic [1:0]            DBG_STATE
);

    // Streak counter must hold the value STARVE_LIMIT itself.
    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t        state;
    logic [SW-1:0] streak;
    logic          owner_cpu;    // 1: current access belongs to the CPU
    logic          owner_write;  // 1: current access is a CPU write

    logic          any_req;
    logic          cpu_wins;
    logic [SW-1:0] streak_next;

    assign DBG_STATE = state;

    // Grant decision and streak bookkeeping for the next grant edge.
    always_comb begin
        any_req     = CPU_REQ | VID_REQ;
        cpu_wins    = CPU_REQ & (~VID_REQ | (streak == STREAK_MAX));
        streak_next = streak;
        if (cpu_wins) begin
            streak_next = '0;
        end else if (CPU_REQ) begin
            // Video won while the CPU waited; count it, saturating.
            streak_next = (streak == STREAK_MAX) ? streak : streak + 1'b1;
        end else begin
            streak_next = '0;
        end
    end

    // Access sequencer: grant, issue to RAM, capture read data, acknowledge.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            streak      <= '0;
            owner_cpu   <= 1'b0;
            owner_write <= 1'b0;
            RAM_ADDR    <= '0;
            RAM_WD      <= '0;
            RAM_WE      <= 1'b0;
            CPU_DO      <= '0;
            VID_DO      <= '0;
            CPU_ACK     <= 1'b0;
            VID_ACK     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    CPU_ACK <= 1'b0;
                    VID_ACK <= 1'b0;
                    if (any_req) begin
                        streak <= streak_next;
                        if (cpu_wins) begin
                            RAM_ADDR    <= CPU_A;
                            RAM_WD      <= CPU_DI;
                            RAM_WE      <= CPU_WE;
                            owner_cpu   <= 1'b1;
                            owner_write <= CPU_WE;
                        end else begin
                            RAM_ADDR    <= VID_A;
                            RAM_WE      <= 1'b0;
                            owner_cpu   <= 1'b0;
                            owner_write <= 1'b0;
                        end
                        state <= ISSUE;
                    end else begin
                        RAM_WE <= 1'b0;
                    end
                end
                ISSUE: begin
                    // RAM samples address/WE on this edge; its Q is valid next.
                    RAM_WE <= 1'b0;
                    state  <= CAPTURE;
                end
                CAPTURE: begin
                    if (owner_cpu) begin
                        // Writes leave CPU_DO holding the last read value.
                        if (!owner_write) begin
                            CPU_DO <= RAM_Q;
                        end
                        CPU_ACK <= 1'b1;
                    end else begin
                        VID_DO  <= RAM_Q;
                        VID_ACK <= 1'b1;
                    end
                    state <= DONE;
                end
                DONE: begin
                    CPU_ACK <= 1'b0;
                    VID_ACK <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    RAM_WE  <= 1'b0;
                    CPU_ACK <= 1'b0;
                    VID_ACK <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: a RAM model, a directed table of single accesses,
// hand-written arbitration sequences, randomized traffic against a
// transaction-level reference model, and a reset taken in mid-access.
module tb_vram_arbiter;

    localparam int AW    = 13;
    localparam int LIMIT = 3;

    // Clock and reset
    logic          CLK = 1'b0;
    logic          RESET;
    logic          CPU_REQ, CPU_WE, VID_REQ;
    logic [AW-1:0] CPU_A, VID_A;
    logic [7:0]    CPU_DI;
    logic [7:0]    CPU_DO, VID_DO;
    logic          CPU_ACK, VID_ACK;
    logic [AW-1:0] RAM_ADDR;
    logic [7:0]    RAM_WD;
    logic          RAM_WE;
    logic [7:0]    RAM_Q;
    logic [1:0]    DBG_STATE;

    always #5 CLK = ~CLK;

    vram_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
        .CLK(CLK), .RESET(RESET),
        .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_A(CPU_A), .CPU_DI(CPU_DI),
        .CPU_DO(CPU_DO), .CPU_ACK(CPU_ACK),
        .VID_REQ(VID_REQ), .VID_A(VID_A), .VID_DO(VID_DO), .VID_ACK(VID_ACK),
        .RAM_ADDR(RAM_ADDR), .RAM_WD(RAM_WD), .RAM_WE(RAM_WE), .RAM_Q(RAM_Q),
        .DBG_STATE(DBG_STATE)
    );

    // Synchronous single-port RAM: Q is valid one clock after the address edge.
    logic [7:0] mem [0:(1<<AW)-1];
    always @(posedge CLK) begin
        if (RAM_WE) mem[RAM_ADDR] <= RAM_WD;
        RAM_Q <= mem[RAM_ADDR];
    end

    // Scoreboard and reference model state
    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] sh [0:(1<<AW)-1];   // shadow memory contents
    int         streak_m;
    logic [7:0] exp_cpu_do, exp_vid_do;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One isolated access, starting from IDLE, with fixed-latency checks.
    task automatic do_access(input bit is_cpu, input bit we, input logic [AW-1:0] a,
                             input logic [7:0] di, input logic [7:0] exp_do);
        @(negedge CLK);
        if (is_cpu) begin
            CPU_REQ = 1'b1; CPU_WE = we; CPU_A = a; CPU_DI = di;
        end else begin
            VID_REQ = 1'b1; VID_A = a;
        end
        @(negedge CLK);  // after grant edge k
        check("grant_addr", RAM_ADDR, a);
        check("grant_we", RAM_WE, is_cpu ? we : 1'b0);
        if (is_cpu && we) check("grant_wd", RAM_WD, di);
        // Inputs other than REQ must not matter after the grant edge.
        CPU_A = ~a; CPU_DI = ~di; CPU_WE = ~we; VID_A = ~a;
        @(negedge CLK);  // after k+1
        check("issue_we_clear", RAM_WE, 0);
        check("issue_no_ack", {CPU_ACK, VID_ACK}, 0);
        @(negedge CLK);  // after k+2
        check("ack_owner", {CPU_ACK, VID_ACK}, is_cpu ? 2'b10 : 2'b01);
        check("ack_data", is_cpu ? CPU_DO : VID_DO, exp_do);
        CPU_REQ = 1'b0; VID_REQ = 1'b0;
        @(negedge CLK);  // after k+3
        check("ack_fall", {CPU_ACK, VID_ACK}, 0);
    endtask

    // Directed vectors
    typedef struct {
        bit            is_cpu;
        bit            we;
        logic [AW-1:0] a;
        logic [7:0]    di;
        logic [7:0]    exp_do;
    } vec_t;
    vec_t tbl[10];

    logic [AW-1:0] pool[16];

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1, 1, 13'h0123, 8'h5A, 8'h00};
        tbl[1] = '{1, 0, 13'h0123, 8'h00, 8'h5A};
        tbl[2] = '{1, 1, 13'h1FFF, 8'hC3, 8'h5A};
        tbl[3] = '{0, 0, 13'h1FFF, 8'h00, 8'hC3};
        tbl[4] = '{1, 1, 13'h0000, 8'h11, 8'h5A};
        tbl[5] = '{0, 0, 13'h0000, 8'h00, 8'h11};
        tbl[6] = '{1, 0, 13'h1FFF, 8'h00, 8'hC3};
        tbl[7] = '{0, 0, 13'h0123, 8'h00, 8'h5A};
        tbl[8] = '{1, 1, 13'h0ABC, 8'h7E, 8'hC3};
        tbl[9] = '{1, 0, 13'h0ABC, 8'h00, 8'h7E};

        RESET = 1'b1;
        CPU_REQ = 0; CPU_WE = 0; CPU_A = '0; CPU_DI = '0;
        VID_REQ = 0; VID_A = '0;
        streak_m = 0; exp_cpu_do = 8'h00; exp_vid_do = 8'h00;

        // Reset state, before any clock edge
        #2;
        check("rst_state", DBG_STATE, 0);
        check("rst_ram_we", RAM_WE, 0);
        check("rst_acks", {CPU_ACK, VID_ACK}, 0);
        check("rst_ram_addr", RAM_ADDR, 0);
        check("rst_ram_wd", RAM_WD, 0);
        check("rst_cpu_do", CPU_DO, 0);
        check("rst_vid_do", VID_DO, 0);
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        check("idle_no_req_we", RAM_WE, 0);
        check("idle_no_req_state", DBG_STATE, 0);

        // Table-driven single accesses
        for (int i = 0; i < 10; i++) begin
            do_access(tbl[i].is_cpu, tbl[i].we, tbl[i].a, tbl[i].di, tbl[i].exp_do);
            if (tbl[i].is_cpu && tbl[i].we) sh[tbl[i].a] = tbl[i].di;
            else if (tbl[i].is_cpu) exp_cpu_do = tbl[i].exp_do;
            else exp_vid_do = tbl[i].exp_do;
        end

        // Simultaneous requests, streak 0: video first, CPU in the next IDLE
        @(negedge CLK);
        VID_REQ = 1; VID_A = 13'h1FFF;
        CPU_REQ = 1; CPU_WE = 0; CPU_A = 13'h0123;
        for (int cyc = 1; cyc <= 7; cyc++) begin
            @(negedge CLK);
            if (cyc == 1) check("sim_vid_addr", RAM_ADDR, 13'h1FFF);
            if (cyc == 3) begin
                check("sim_vid_ack", {CPU_ACK, VID_ACK}, 2'b01);
                check("sim_vid_do", VID_DO, sh[13'h1FFF]);
                VID_REQ = 0;
            end else if (cyc == 7) begin
                check("sim_cpu_ack", {CPU_ACK, VID_ACK}, 2'b10);
                check("sim_cpu_do", CPU_DO, sh[13'h0123]);
                CPU_REQ = 0;
            end else begin
                check("sim_no_ack", {CPU_ACK, VID_ACK}, 0);
            end
            if (cyc == 5) check("sim_cpu_addr", RAM_ADDR, 13'h0123);
        end
        exp_vid_do = sh[13'h1FFF];
        exp_cpu_do = sh[13'h0123];
        @(negedge CLK);

        // Starvation: video held high throughout, CPU waits
        begin
            int order[$];
            int exp_order[5];
            int t_last;
            exp_order = '{0, 0, 0, 1, 0};
            t_last = 0;
            VID_REQ = 1; VID_A = 13'h0000;
            CPU_REQ = 1; CPU_WE = 0; CPU_A = 13'h0ABC;
            for (int cyc = 1; cyc <= 30 && order.size() < 5; cyc++) begin
                @(negedge CLK);
                check("starve_excl", CPU_ACK & VID_ACK, 0);
                if (CPU_ACK || VID_ACK) begin
                    check("starve_gap", cyc - t_last, (t_last == 0) ? 3 : 4);
                    t_last = cyc;
                end
                if (VID_ACK) begin
                    order.push_back(0);
                    check("starve_vid_do", VID_DO, sh[13'h0000]);
                end
                if (CPU_ACK) begin
                    order.push_back(1);
                    check("starve_cpu_do", CPU_DO, sh[13'h0ABC]);
                    CPU_REQ = 0;
                end
            end
            VID_REQ = 0;
            check("starve_count", order.size(), 5);
            for (int i = 0; i < order.size() && i < 5; i++)
                check("starve_order", order[i], exp_order[i]);
            exp_cpu_do = sh[13'h0ABC];
            exp_vid_do = sh[13'h0000];
            @(negedge CLK);
        end

        // Randomized traffic: seed a pool of addresses, then mixed requests
        for (int i = 0; i < 16; i++) begin
            logic [7:0] d;
            pool[i] = AW'($urandom_range(0, (1<<AW)-1));
            d = 8'($urandom_range(0, 255));
            do_access(1, 1, pool[i], d, exp_cpu_do);
            sh[pool[i]] = d;
        end
        streak_m = 0;
        begin
            bit cpu_p, vid_p, cpu_win, got;
            logic [AW-1:0] ca, va;
            bit cwe;
            logic [7:0] cdi, obs;
            cpu_p = 0; vid_p = 0;
            @(negedge CLK);
            for (int n = 0; n < 60; n++) begin
                if (!cpu_p && $urandom_range(0, 1) == 1) begin
                    ca = pool[$urandom_range(0, 15)];
                    cwe = 1'($urandom_range(0, 1));
                    cdi = 8'($urandom_range(0, 255));
                    CPU_REQ = 1; CPU_A = ca; CPU_WE = cwe; CPU_DI = cdi; cpu_p = 1;
                end
                if (!vid_p && (cpu_p == 0 || $urandom_range(0, 1) == 1)) begin
                    va = pool[$urandom_range(0, 15)];
                    VID_REQ = 1; VID_A = va; vid_p = 1;
                end
                // Reference: video wins unless the CPU has waited LIMIT grants
                cpu_win = cpu_p && (!vid_p || streak_m == LIMIT);
                if (cpu_win) streak_m = 0;
                else if (cpu_p) streak_m = (streak_m < LIMIT) ? streak_m + 1 : LIMIT;
                else streak_m = 0;
                if (cpu_win) begin
                    if (cwe) sh[ca] = cdi;
                    else exp_cpu_do = sh[ca];
                    exp_q.push_back(exp_cpu_do);
                end else begin
                    exp_vid_do = sh[va];
                    exp_q.push_back(exp_vid_do);
                end
                got = 0;
                for (int c = 0; c < 6 && !got; c++) begin
                    @(negedge CLK);
                    check("rand_excl", CPU_ACK & VID_ACK, 0);
                    if (CPU_ACK || VID_ACK) got = 1;
                end
                check("rand_ack_seen", got, 1);
                if (got) begin
                    check("rand_winner", CPU_ACK, cpu_win);
                    obs = CPU_ACK ? CPU_DO : VID_DO;
                    check("rand_data", obs, exp_q.pop_front());
                    check("rand_cpu_do_hold", CPU_DO, exp_cpu_do);
                    check("rand_vid_do_hold", VID_DO, exp_vid_do);
                end else begin
                    void'(exp_q.pop_front());
                end
                if (cpu_win) begin CPU_REQ = 0; cpu_p = 0; end
                else begin VID_REQ = 0; vid_p = 0; end
            end
            CPU_REQ = 0; VID_REQ = 0;
            @(negedge CLK);
        end

        // Reset during CAPTURE: access abandoned, outputs cleared
        @(negedge CLK);
        CPU_REQ = 1; CPU_WE = 0; CPU_A = pool[0];
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        check("mid_rst_state", DBG_STATE, 0);
        check("mid_rst_outs", {RAM_WE, CPU_ACK, VID_ACK}, 0);
        check("mid_rst_addr", RAM_ADDR, 0);
        check("mid_rst_wd", RAM_WD, 0);
        check("mid_rst_dos", {CPU_DO, VID_DO}, 0);
        CPU_REQ = 0;
        @(negedge CLK);
        check("mid_rst_no_ack", {CPU_ACK, VID_ACK}, 0);
        RESET = 1'b0;
        streak_m = 0; exp_cpu_do = 8'h00; exp_vid_do = 8'h00;
        do_access(1, 0, pool[0], 8'h00, sh[pool[0]]);
        check("post_rst_vid_do", VID_DO, exp_vid_do);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 13: width of the shared video RAM address (8KB).
REQ-002 The block SHALL have parameter STARVE_LIMIT, default 3: maximum consecutive video grants while a CPU request waits.
REQ-003 Port CLK, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port RESET, input, 1: reset, asynchronous and active-high.
REQ-005 Port CPU_REQ, input, 1: CPU access request, level, held until CPU_ACK.
REQ-006 Port CPU_WE, input, 1: 1 means write, 0 means read; sampled at grant.
REQ-007 Port CPU_A, input, ADDR_WIDTH: CPU address; sampled at grant.
REQ-008 Port CPU_DI, input, 8: CPU write data; sampled at grant.
REQ-009 Port CPU_DO, output, 8: CPU read data, valid while CPU_ACK is high.
REQ-010 Port CPU_ACK, output, 1: one-cycle completion pulse for a CPU access.
REQ-011 Port VID_REQ, input, 1: CRTC fetch request, read only, level, held until VID_ACK.
REQ-012 Port VID_A, input, ADDR_WIDTH: fetch address from MA/RA; sampled at grant.
REQ-013 Port VID_DO, output, 8: fetch data, valid while VID_ACK is high.
REQ-014 Port VID_ACK, output, 1: one-cycle completion pulse for a fetch.
REQ-015 Port RAM_ADDR, output, ADDR_WIDTH: registered address to the synchronous single-port RAM.
REQ-016 Port RAM_WD, output, 8: registered write data to the RAM.
REQ-017 Port RAM_WE, output, 1: registered write enable to the RAM.
REQ-018 Port RAM_Q, input, 8: RAM read data, valid one clock after the address edge.

Function
REQ-019 The FSM SHALL have exactly the states IDLE, ISSUE, CAPTURE and DONE; IDLE is the reset state.
REQ-020 In IDLE with any request high at edge k, the block SHALL register the winner's address, data and WE into RAM_ADDR/RAM_WD/RAM_WE and enter ISSUE.
REQ-021 In IDLE with no request, the block SHALL stay in IDLE with RAM_WE=0.
REQ-022 At edge k+1 the block SHALL enter CAPTURE and clear RAM_WE.
REQ-023 At edge k+2 the block SHALL load RAM_Q into the winner's DO register, pulse that requester's ACK high, and enter DONE.
REQ-024 At edge k+3 the block SHALL clear ACK and return to IDLE; throughput is one access per 4 cycles.
REQ-025 A request still high in the cycle after ACK falls (IDLE) SHALL be treated as a new request.
REQ-026 For a CPU write, CPU_DO SHALL keep its previous value and CPU_ACK SHALL pulse with the same timing as a read.
REQ-027 Request inputs other than REQ SHALL be ignored outside the grant edge; mid-access changes have no effect.
REQ-028 Arbitration SHALL give VID priority, except that when the counter streak equals STARVE_LIMIT and CPU_REQ is high, CPU SHALL win.
REQ-029 The streak SHALL be updated at each grant edge:
  - video grant with CPU_REQ high: streak+1, saturating at STARVE_LIMIT;
  - video grant with CPU_REQ low: streak cleared to 0;
  - CPU grant: streak cleared to 0.
REQ-030 A single request SHALL be granted regardless of the streak value.
REQ-031 CPU_DO and VID_DO SHALL each hold their value until that requester's next read capture.
REQ-032 CPU_ACK and VID_ACK SHALL never both be high in the same cycle.

Reset
REQ-033 While RESET is high, the block SHALL immediately force:
  - state to IDLE and streak to 0;
  - RAM_WE, CPU_ACK and VID_ACK to 0;
  - RAM_ADDR, RAM_WD, CPU_DO and VID_DO to 0.
REQ-034 Reset asserted mid-access SHALL abandon the access with no ACK; an interrupted write is not guaranteed.
REQ-035 After RESET falls, the first grant SHALL occur at the first rising edge at which a request is high.

Verification
REQ-036 A CPU read: RAM[0x0123]=0x5A, CPU_REQ=1, CPU_WE=0, CPU_A=0x0123 -> RAM_ADDR=0x0123 after edge k; CPU_DO=0x5A with CPU_ACK high for exactly one cycle after edge k+2.
REQ-037 A CPU write: CPU_A=0x1FFF, CPU_DI=0xC3, CPU_WE=1 -> RAM_WE high for exactly one cycle; a later fetch VID_A=0x1FFF returns VID_DO=0xC3.
REQ-038 Simultaneous requests with streak 0 -> video served first, then CPU granted in the IDLE cycle immediately after VID_ACK.
REQ-039 Starvation: VID_REQ continuously high and CPU_REQ high -> 3 video grants, then a CPU grant, then video resumes.
REQ-040 Reset mid-access: RESET pulsed during CAPTURE -> no ACK, all outputs 0 during reset; a new CPU read completes normally after release.
